// File: rtl/multi_code_counter_pkg.sv
// Shared definitions for the multi-code counter family: output-code selectors
// and the BCD load sanitiser.
package multi_code_counter_pkg;

  localparam logic [1:0] MODE_BIN  = 2'b00;
  localparam logic [1:0] MODE_GRAY = 2'b01;
  localparam logic [1:0] MODE_BCD  = 2'b10;
  localparam logic [1:0] MODE_HOLD = 2'b11;

  // Nibbles that are not valid decimal digits are forced to zero.
  function automatic logic [3:0] bcd_digit_clamp(input logic [3:0] digit);
    return (digit > 4'd9) ? 4'd0 : digit;
  endfunction

endpackage

// File: rtl/multi_code_counter_bcd_digit_step.sv
// One decimal digit of the BCD chain: steps by one when carry_in is set,
// 9->0 going up and 0->9 going down, reporting carry/borrow to the next digit.
module bcd_digit_step (
  input  logic [3:0] digit,
  input  logic       up,
  input  logic       carry_in,
  output logic [3:0] digit_next,
  output logic       carry_out
);

  always_comb begin
    digit_next = digit;
    carry_out  = 1'b0;
    if (carry_in) begin
      if (up) begin
        if (digit >= 4'd9) begin
          digit_next = 4'd0;
          carry_out  = 1'b1;
        end else begin
          digit_next = digit + 4'd1;
        end
      end else begin
        if (digit == 4'd0) begin
          digit_next = 4'd9;
          carry_out  = 1'b1;
        end else begin
          digit_next = digit - 4'd1;
        end
      end
    end
  end

endmodule

// File: rtl/multi_code_counter.sv
// Up/down counter with run-time selectable output code (binary, Gray, packed BCD),
// synchronous load and a registered one-cycle wrap flag.
module multi_code_counter
  import multi_code_counter_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       mode,
  input  logic             enable,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic [WIDTH-1:0] counter,
  output logic             out_flag
);

  localparam logic BCD_OK = (WIDTH % 4 == 0);
  localparam int   NDIG   = (WIDTH / 4 > 0) ? (WIDTH / 4) : 1;

  logic [1:0]       mode_reg;
  logic [WIDTH-1:0] cnt_reg, cnt_next;
  logic [WIDTH-1:0] counter_reg, counter_next;
  logic             flag_reg, flag_next;

  logic [WIDTH-1:0] bin_step, bcd_step, bcd_load;
  logic             bin_wrap, bcd_wrap;
  logic             is_bcd, hold_mode;

  assign bin_step = up ? (cnt_reg + WIDTH'(1)) : (cnt_reg - WIDTH'(1));
  assign bin_wrap = up ? (cnt_reg == {WIDTH{1'b1}}) : (cnt_reg == '0);

  // Decimal chain: digit 0 always receives the step, higher digits ripple.
  generate
    if (BCD_OK) begin : g_bcd
      logic [NDIG:0] carry;
      assign carry[0] = 1'b1;
      for (genvar gi = 0; gi < NDIG; gi++) begin : g_digit
        bcd_digit_step u_step (
          .digit     (cnt_reg[4*gi +: 4]),
          .up        (up),
          .carry_in  (carry[gi]),
          .digit_next(bcd_step[4*gi +: 4]),
          .carry_out (carry[gi+1])
        );
        assign bcd_load[4*gi +: 4] = bcd_digit_clamp(load_value[4*gi +: 4]);
      end
      assign bcd_wrap = carry[NDIG];
    end else begin : g_no_bcd
      assign bcd_step = cnt_reg;
      assign bcd_load = load_value;
      assign bcd_wrap = 1'b0;
    end
  endgenerate

  assign is_bcd    = (mode_reg == MODE_BCD);
  assign hold_mode = (mode_reg == MODE_HOLD) || (is_bcd && !BCD_OK);

  always_comb begin
    cnt_next  = cnt_reg;
    flag_next = 1'b0;
    if (mode != mode_reg) begin
      cnt_next = '0;
    end else if (!hold_mode) begin
      if (load) begin
        cnt_next = is_bcd ? bcd_load : load_value;
      end else if (enable) begin
        cnt_next  = is_bcd ? bcd_step : bin_step;
        flag_next = is_bcd ? bcd_wrap : bin_wrap;
      end
    end
  end

  // Encode from the incoming mode; on a mode change cnt_next is zero, so the code is zero too.
  always_comb begin
    counter_next = cnt_next;
    if (mode == MODE_GRAY) begin
      counter_next = cnt_next ^ (cnt_next >> 1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mode_reg    <= MODE_BIN;
      cnt_reg     <= '0;
      counter_reg <= '0;
      flag_reg    <= 1'b0;
    end else begin
      mode_reg    <= mode;
      cnt_reg     <= cnt_next;
      counter_reg <= counter_next;
      flag_reg    <= flag_next;
    end
  end

  assign counter  = counter_reg;
  assign out_flag = flag_reg;

endmodule

// File: tb/tb_multi_code_counter.sv
// Directed bench for multi_code_counter: a 4-bit and an 8-bit instance share clock
// and reset; vector table plus hand sequences for reset corners.
module tb_multi_code_counter;

  logic       clk;
  logic       reset;
  logic [1:0] m4, m8;
  logic       en4, en8, up4, up8, ld4, ld8;
  logic [3:0] lv4, cnt4;
  logic [7:0] lv8, cnt8;
  logic       flag4, flag8;

  int checks;
  int errors;

  typedef struct {
    logic       sel;
    logic [1:0] mode;
    logic       en;
    logic       up;
    logic       ld;
    logic [7:0] lv;
    logic [7:0] exp_cnt;
    logic       exp_flag;
  } vec_t;

  vec_t vq[$];

  multi_code_counter #(.WIDTH(4)) dut4 (
    .clk(clk), .reset(reset), .mode(m4), .enable(en4), .up(up4), .load(ld4),
    .load_value(lv4), .counter(cnt4), .out_flag(flag4)
  );

  multi_code_counter #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(reset), .mode(m8), .enable(en8), .up(up8), .load(ld8),
    .load_value(lv8), .counter(cnt8), .out_flag(flag8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", name, got, exp);
    end else begin
      $display("ok   %s = %h", name, got);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic s, input logic [1:0] m, input logic e, input logic u,
                     input logic l, input logic [7:0] lv, input logic [7:0] ec, input logic ef);
    vec_t v;
    v.sel = s; v.mode = m; v.en = e; v.up = u; v.ld = l;
    v.lv = lv; v.exp_cnt = ec; v.exp_flag = ef;
    vq.push_back(v);
  endtask

  logic [3:0] gray_seq [16];

  initial begin
    gray_seq = '{4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4, 4'hC,
                 4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8, 4'h0};
    checks = 0;
    errors = 0;
    reset = 1'b0;
    m4 = 2'b00; en4 = 0; up4 = 1; ld4 = 0; lv4 = '0;
    m8 = 2'b00; en8 = 0; up8 = 1; ld8 = 0; lv8 = '0;

    // 4-bit binary up through wrap
    for (int i = 1; i <= 16; i++) add(0, 2'b00, 1, 1, 0, 8'h00, 8'(i % 16), (i == 16));
    add(0, 2'b00, 0, 1, 0, 8'h00, 8'h00, 0);
    // 4-bit Gray sequence
    add(0, 2'b01, 0, 1, 0, 8'h00, 8'h00, 0);
    for (int i = 0; i < 16; i++) add(0, 2'b01, 1, 1, 0, 8'h00, {4'h0, gray_seq[i]}, (i == 15));
    add(0, 2'b01, 0, 1, 0, 8'h00, 8'h00, 0);
    // Binary down wrap, then mode change beats load and enable
    add(0, 2'b00, 0, 1, 0, 8'h00, 8'h00, 0);
    add(0, 2'b00, 1, 0, 0, 8'h00, 8'h0F, 1);
    add(0, 2'b00, 1, 0, 0, 8'h00, 8'h0E, 0);
    add(0, 2'b00, 0, 1, 1, 8'h05, 8'h05, 0);
    add(0, 2'b01, 1, 1, 1, 8'h05, 8'h00, 0);
    add(0, 2'b01, 1, 1, 0, 8'h00, 8'h01, 0);
    add(0, 2'b01, 1, 1, 0, 8'h00, 8'h03, 0);
    add(0, 2'b01, 0, 1, 1, 8'h0A, 8'h0F, 0);
    add(0, 2'b01, 1, 0, 0, 8'h00, 8'h0D, 0);
    add(0, 2'b01, 0, 1, 1, 8'h0F, 8'h08, 0);
    add(0, 2'b01, 1, 1, 0, 8'h00, 8'h00, 1);
    // HOLD freezes the count
    add(0, 2'b11, 1, 1, 1, 8'h05, 8'h00, 0);
    add(0, 2'b11, 1, 1, 0, 8'h00, 8'h00, 0);
    add(0, 2'b11, 0, 1, 1, 8'h09, 8'h00, 0);
    // 4-bit BCD: single digit
    add(0, 2'b10, 0, 1, 0, 8'h00, 8'h00, 0);
    add(0, 2'b10, 0, 1, 1, 8'h0C, 8'h00, 0);
    add(0, 2'b10, 0, 1, 1, 8'h09, 8'h09, 0);
    add(0, 2'b10, 1, 1, 0, 8'h00, 8'h00, 1);
    add(0, 2'b10, 1, 0, 0, 8'h00, 8'h09, 1);
    // 8-bit BCD
    add(1, 2'b10, 0, 1, 0, 8'h00, 8'h00, 0);
    add(1, 2'b10, 0, 1, 1, 8'h98, 8'h98, 0);
    add(1, 2'b10, 1, 1, 0, 8'h00, 8'h99, 0);
    add(1, 2'b10, 1, 1, 0, 8'h00, 8'h00, 1);
    add(1, 2'b10, 1, 0, 0, 8'h00, 8'h99, 1);
    add(1, 2'b10, 1, 0, 0, 8'h00, 8'h98, 0);
    add(1, 2'b10, 0, 1, 1, 8'hA3, 8'h03, 0);
    add(1, 2'b10, 1, 1, 1, 8'h45, 8'h45, 0);
    add(1, 2'b10, 1, 1, 0, 8'h00, 8'h46, 0);
    add(1, 2'b10, 0, 1, 1, 8'h1F, 8'h10, 0);
    add(1, 2'b10, 1, 0, 0, 8'h00, 8'h09, 0);
    add(1, 2'b10, 1, 1, 0, 8'h00, 8'h10, 0);
    add(1, 2'b10, 0, 1, 1, 8'hFF, 8'h00, 0);
    add(1, 2'b10, 1, 0, 0, 8'h00, 8'h99, 1);
    add(1, 2'b10, 0, 1, 0, 8'h00, 8'h99, 0);
    // 8-bit binary wrap
    add(1, 2'b00, 0, 1, 0, 8'h00, 8'h00, 0);
    add(1, 2'b00, 0, 1, 1, 8'hFF, 8'hFF, 0);
    add(1, 2'b00, 1, 1, 0, 8'h00, 8'h00, 1);

    repeat (2) @(posedge clk);
    #1;
    chk("reset cnt4", {4'h0, cnt4}, 8'h00);
    chk("reset flag4", {7'h0, flag4}, 8'h00);
    chk("reset cnt8", cnt8, 8'h00);
    chk("reset flag8", {7'h0, flag8}, 8'h00);
    @(negedge clk);
    reset = 1'b1;
    tick;

    for (int i = 0; i < vq.size(); i++) begin
      vec_t v;
      v = vq[i];
      if (v.sel) begin
        m8 = v.mode; en8 = v.en; up8 = v.up; ld8 = v.ld; lv8 = v.lv;
        en4 = 0; ld4 = 0;
      end else begin
        m4 = v.mode; en4 = v.en; up4 = v.up; ld4 = v.ld; lv4 = v.lv[3:0];
        en8 = 0; ld8 = 0;
      end
      tick;
      chk($sformatf("vec%0d counter", i), v.sel ? cnt8 : {4'h0, cnt4}, v.exp_cnt);
      chk($sformatf("vec%0d flag", i), {7'h0, v.sel ? flag8 : flag4}, {7'h0, v.exp_flag});
    end
    en8 = 0; ld8 = 0;

    // Asynchronous reset mid-count at 6
    m4 = 2'b00; en4 = 0; ld4 = 0; up4 = 1;
    tick;
    en4 = 1;
    repeat (6) tick;
    chk("pre-reset cnt4", {4'h0, cnt4}, 8'h06);
    #3;
    reset = 1'b0;
    #1;
    chk("async reset cnt4", {4'h0, cnt4}, 8'h00);
    chk("async reset flag4", {7'h0, flag4}, 8'h00);
    tick;
    chk("reset held cnt4", {4'h0, cnt4}, 8'h00);
    // First edge after release: mode input Gray differs from reset mode
    @(negedge clk);
    m4 = 2'b01;
    reset = 1'b1;
    tick;
    chk("release mode change cnt4", {4'h0, cnt4}, 8'h00);
    tick;
    chk("release step1 cnt4", {4'h0, cnt4}, 8'h01);
    up4 = 0;
    tick;
    chk("dir change cnt4", {4'h0, cnt4}, 8'h00);
    chk("dir change flag4", {7'h0, flag4}, 8'h00);
    tick;
    chk("gray down wrap cnt4", {4'h0, cnt4}, 8'h08);
    chk("gray down wrap flag4", {7'h0, flag4}, 8'h01);
    en4 = 0;
    tick;
    chk("flag one cycle", {7'h0, flag4}, 8'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
